bpsk_demod_ctrl: RTL and testbench
==================================

Name: bpsk_demod_ctrl

Overview:
Sequencer for the combinational BPSK demodulator. It collects FFT_SIZE serial FFT real-part samples per OFDM symbol using a valid/ready handshake and aligns on start-of-symbol. It presents the full symbol in parallel to the demodulator, captures the FFT_SIZE decided bits, and emits one bit-word per symbol with valid/ready backpressure. It sits between the FFT output stage and the bit sink/deframer.

Parameters:
WIDTH, 16, bit width of each signed real sample
FFT_SIZE, 16, samples (bins) per symbol; power of two, ≥2
CNT_W, 16, width of emitted-symbol counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
din_real  in  WIDTH  signed serial sample, bin order 0..FFT_SIZE-1
din_valid  in  1  din_real/din_sop valid
din_sop  in  1  marks bin 0 of a symbol
din_ready  out  1  controller accepts sample this cycle
demod_din  out  FFT_SIZE*WIDTH  to demodulator; lane i = bits [i*WIDTH +: WIDTH] -> din<i>_real
demod_dout  in  FFT_SIZE  from demodulator; bit i = decision for lane i
dout_bits  out  FFT_SIZE  demodulated symbol; bit i = bin i (1 = negative sample)
dout_valid  out  1  dout_bits valid
dout_ready  in  1  sink accepts dout_bits
sop_err  out  1  one-cycle pulse: alignment error
sym_cnt  out  CNT_W  symbols emitted, wraps modulo 2^CNT_W
busy  out  1  partial or full symbol held in buffer

Behaviour:
- Reset (rst_n=0 at edge): input state FILL, idx=0, buffer lanes=0, dout_bits=0, dout_valid=0, sop_err=0, sym_cnt=0. busy=0. din_ready=1 from the first cycle after reset. Reset mid-symbol discards partial and held data.
- Input FSM, states FILL and FULL:
  - FILL: din_ready=1. A sample is accepted when din_valid=1.
    - idx==0, sop=1: store lane 0, idx=1.
    - idx==0, sop=0: sample dropped, sop_err pulses, idx stays 0.
    - idx>0, sop=0: store lane idx, idx++.
    - idx>0, sop=1: partial symbol discarded, sop_err pulses, sample stored as lane 0, idx=1.
    - Storing lane FFT_SIZE-1: idx wraps to 0, next state FULL.
  - FULL: din_ready=0; buffer stable.
- Transfer: in FULL, when dout_valid==0 or dout_ready==1, at that edge dout_bits<=demod_dout, dout_valid<=1, sym_cnt++, state<=FILL. Otherwise stay in FULL (backpressure to FFT).
- Output handshake: dout_valid falls after the edge with dout_ready=1 unless a transfer happens at the same edge, in which case dout_valid stays 1 with new bits. dout_bits and dout_valid are held stable while dout_valid=1 and dout_ready=0.
- Latency: last-sample accept edge E0 -> FULL -> capture at E1 -> dout_valid=1 in the cycle after E1 (2 cycles), when the output is free.
- Overlap: one symbol may be in the output register while the next fills the buffer. Sustained throughput is FFT_SIZE samples per FFT_SIZE+1 cycles.
- demod_din is driven directly from the buffer registers and must be stable throughout FULL.
- Demod rule (performed by the demodulator, checked by the bench): bit = sign bit. Zero -> 0; negative -> 1.
- busy = (idx!=0) or FULL.
- sym_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package bpsk_pkg: WIDTH/FFT_SIZE defaults, IDX_W=$clog2(FFT_SIZE), state encoding FILL=1'b0 / FULL=1'b1.
- One sub-module, bpsk_s2p_buf: serial-to-parallel register bank with write-enable, index, and flattened parallel output.
- The demodulator is instantiated alongside in the receiver top, not inside this block.

Test Plan:
- Reset then 16 samples, sop on first, values alternating +100/-100 (bin0 positive), dout_ready=1 -> dout_bits=16'hAAAA with dout_valid 2 cycles after the last accept, sym_cnt=1.
- Samples all 0 except bin 15 = -1 -> dout_bits=16'h8000 (zero decodes as 0).
- Two back-to-back symbols, dout_ready=0 until both buffered -> din_ready=0 after the 32nd sample. First word held stable; after ready is asserted, the second word follows the next cycle and sym_cnt=2.
- sop on the 6th sample of a symbol -> sop_err pulses once; the symbol restarts, and the output reflects only the new 16 samples.
- Sample without sop while idx=0 -> dropped, sop_err=1 for one cycle, no dout_valid.
- rst_n=0 for one cycle after 8 samples and with a word pending -> dout_valid=0, sym_cnt=0, busy=0; the next full symbol decodes correctly.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared defaults and input-state encoding for the BPSK demodulator sequencer.
package bpsk_pkg;

  localparam int BPSK_WIDTH    = 16;
  localparam int BPSK_FFT_SIZE = 16;
  localparam int IDX_W         = $clog2(BPSK_FFT_SIZE);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/bpsk_s2p_buf.sv
// Serial-to-parallel lane bank: one lane written per enabled cycle, all lanes visible flat.
// Latency: write visible on par_dat the cycle after wr_en; no backpressure (writer gates wr_en).
module bpsk_s2p_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [DEPTH*WIDTH-1:0]   par_dat
);

  logic [DEPTH-1:0][WIDTH-1:0] lanes_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q <= '0;
    end else if (wr_en) begin
      lanes_q[wr_idx] <= wr_dat;
    end
  end

  assign par_dat = lanes_q;

endmodule

// File: rtl/bpsk_demod_ctrl.sv
// Collects one OFDM symbol of serial samples, hands it to the demodulator, registers the bits.
// Latency: 2 cycles last accept -> dout_valid; din_ready drops while a full symbol waits for the output.
module bpsk_demod_ctrl
  import bpsk_pkg::*;
#(
  parameter int WIDTH    = BPSK_WIDTH,
  parameter int FFT_SIZE = BPSK_FFT_SIZE,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din_real,
  input  logic                      din_valid,
  input  logic                      din_sop,
  output logic                      din_ready,
  output logic [FFT_SIZE*WIDTH-1:0] demod_din,
  input  logic [FFT_SIZE-1:0]       demod_dout,
  output logic [FFT_SIZE-1:0]       dout_bits,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      sop_err,
  output logic [CNT_W-1:0]          sym_cnt,
  output logic                      busy
);

  localparam int IW = $clog2(FFT_SIZE);
  localparam logic [IW-1:0] LAST = IW'(FFT_SIZE - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] wr_idx;
  logic          acc, wr_en, err_d, xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          if (wr_idx == LAST) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = wr_idx + 1'b1;
          end
        end
      end
      FULL: begin
        if (xfer) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // A sop always restarts at lane 0; a non-sop sample at idx 0 has no symbol to join.
  always_comb begin
    din_ready = (state_q == FILL);
    acc       = din_ready && din_valid;
    wr_en     = acc && (din_sop || (idx_q != '0));
    wr_idx    = din_sop ? '0 : idx_q;
    err_d     = acc && ((idx_q == '0) ^ din_sop);
    xfer      = (state_q == FULL) && (!dout_valid || dout_ready);
    busy      = (idx_q != '0) || (state_q == FULL);
  end

  bpsk_s2p_buf #(
    .WIDTH (WIDTH),
    .DEPTH (FFT_SIZE),
    .IDX_W (IW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_dat  (din_real),
    .par_dat (demod_din)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_bits  <= '0;
      dout_valid <= 1'b0;
      sop_err    <= 1'b0;
      sym_cnt    <= '0;
    end else begin
      sop_err <= err_d;
      if (xfer) begin
        dout_bits  <= demod_dout;
        dout_valid <= 1'b1;
        sym_cnt    <= sym_cnt + 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demod_ctrl.sv
// Directed bench for bpsk_demod_ctrl; a sign-bit demodulator is modelled alongside the DUT.
module tb_bpsk_demod_ctrl;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    din_real;
  logic            din_valid;
  logic            din_sop;
  logic            din_ready;
  logic [N*W-1:0]  demod_din;
  logic [N-1:0]    demod_dout;
  logic [N-1:0]    dout_bits;
  logic            dout_valid;
  logic            dout_ready;
  logic            sop_err;
  logic [CW-1:0]   sym_cnt;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bpsk_demod_ctrl #(.WIDTH(W), .FFT_SIZE(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_real   (din_real),
    .din_valid  (din_valid),
    .din_sop    (din_sop),
    .din_ready  (din_ready),
    .demod_din  (demod_din),
    .demod_dout (demod_dout),
    .dout_bits  (dout_bits),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sop_err    (sop_err),
    .sym_cnt    (sym_cnt),
    .busy       (busy)
  );

  // Demodulator: decision is the sample's sign bit.
  always_comb begin
    demod_dout = '0;
    for (int i = 0; i < N; i++) demod_dout[i] = demod_din[i*W + W - 1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [W-1:0] v, input logic sop);
    int waitc;
    din_real  = v;
    din_sop   = sop;
    din_valid = 1'b1;
    waitc     = 0;
    while (!din_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    if (!din_ready) check("din_ready_timeout", {31'd0, din_ready}, 32'd1);
    tick();
    din_valid = 1'b0;
    din_sop   = 1'b0;
  endtask

  task automatic send_symbol(input logic [N-1:0] neg_mask, input int pos_v, input int neg_v);
    for (int i = 0; i < N; i++)
      send_sample(neg_mask[i] ? W'(neg_v) : W'(pos_v), (i == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    din_real   = '0;
    din_valid  = 1'b0;
    din_sop    = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_sym_cnt",    {16'd0, sym_cnt},    32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_dout_bits",  {16'd0, dout_bits},  32'd0);
    check("rst_sop_err",    {31'd0, sop_err},    32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_din_ready",  {31'd0, din_ready},  32'd1);

    // Alternating +100/-100, bin 0 positive.
    send_symbol(16'hAAAA, 100, -100);
    check("t1_valid_e0",    {31'd0, dout_valid}, 32'd0);
    check("t1_ready_full",  {31'd0, din_ready},  32'd0);
    check("t1_busy_full",   {31'd0, busy},       32'd1);
    tick();
    check("t1_valid",       {31'd0, dout_valid}, 32'd1);
    check("t1_bits",        {16'd0, dout_bits},  32'h0000AAAA);
    check("t1_cnt",         {16'd0, sym_cnt},    32'd1);
    check("t1_ready_again", {31'd0, din_ready},  32'd1);
    tick();
    check("t1_valid_drop",  {31'd0, dout_valid}, 32'd0);

    // Zero samples decode as 0; only bin 15 negative.
    send_symbol(16'h8000, 0, -1);
    tick();
    check("t2_bits",        {16'd0, dout_bits},  32'h00008000);
    check("t2_cnt",         {16'd0, sym_cnt},    32'd2);
    tick();

    // Two symbols buffered behind a stalled sink.
    dout_ready = 1'b0;
    send_symbol(16'h5555, 5, -5);
    send_symbol(16'h00FF, 300, -32768);
    check("t3_ready_low",   {31'd0, din_ready},  32'd0);
    check("t3_valid_held",  {31'd0, dout_valid}, 32'd1);
    check("t3_bits_first",  {16'd0, dout_bits},  32'h00005555);
    check("t3_cnt_first",   {16'd0, sym_cnt},    32'd3);
    tick();
    tick();
    check("t3_bits_stable", {16'd0, dout_bits},  32'h00005555);
    check("t3_ready_still", {31'd0, din_ready},  32'd0);
    check("t3_lane0",       {16'd0, demod_din[0 +: W]},    32'h00008000);
    check("t3_lane15",      {16'd0, demod_din[15*W +: W]}, 32'h0000012C);
    dout_ready = 1'b1;
    tick();
    check("t3_bits_second", {16'd0, dout_bits},  32'h000000FF);
    check("t3_valid_second",{31'd0, dout_valid}, 32'd1);
    check("t3_cnt_second",  {16'd0, sym_cnt},    32'd4);
    tick();
    check("t3_valid_drop",  {31'd0, dout_valid}, 32'd0);

    // sop on the 6th sample restarts the symbol.
    for (int i = 0; i < 5; i++) send_sample(16'hFFF9, (i == 0));
    check("t4_no_err_yet",  {31'd0, sop_err},    32'd0);
    check("t4_busy",        {31'd0, busy},       32'd1);
    send_sample(16'd1, 1'b1);
    check("t4_sop_err",     {31'd0, sop_err},    32'd1);
    for (int i = 1; i < N; i++) begin
      send_sample((i == 3) ? 16'hFFFF : 16'd1, 1'b0);
      if (i == 1) check("t4_err_pulse", {31'd0, sop_err}, 32'd0);
    end
    tick();
    check("t4_bits",        {16'd0, dout_bits},  32'h00000008);
    check("t4_cnt",         {16'd0, sym_cnt},    32'd5);
    tick();

    // Sample without sop at idx 0 is dropped.
    send_sample(16'd50, 1'b0);
    check("t5_sop_err",     {31'd0, sop_err},    32'd1);
    check("t5_busy",        {31'd0, busy},       32'd0);
    tick();
    check("t5_err_clear",   {31'd0, sop_err},    32'd0);
    tick();
    tick();
    check("t5_no_valid",    {31'd0, dout_valid}, 32'd0);
    check("t5_cnt",         {16'd0, sym_cnt},    32'd5);

    // Reset with a word pending and a partial symbol in the buffer.
    dout_ready = 1'b0;
    send_symbol(16'hFFFF, 3, -3);
    tick();
    check("t6_pending",     {31'd0, dout_valid}, 32'd1);
    check("t6_cnt_pre",     {16'd0, sym_cnt},    32'd6);
    for (int i = 0; i < 8; i++) send_sample(16'd9, (i == 0));
    check("t6_busy_pre",    {31'd0, busy},       32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_valid",       {31'd0, dout_valid}, 32'd0);
    check("t6_cnt",         {16'd0, sym_cnt},    32'd0);
    check("t6_busy",        {31'd0, busy},       32'd0);
    check("t6_bits",        {16'd0, dout_bits},  32'd0);
    check("t6_lane0_clr",   {16'd0, demod_din[0 +: W]}, 32'd0);
    check("t6_din_ready",   {31'd0, din_ready},  32'd1);
    dout_ready = 1'b1;
    send_symbol(16'h1234, 32767, -2);
    tick();
    check("t6_bits_after",  {16'd0, dout_bits},  32'h00001234);
    check("t6_valid_after", {31'd0, dout_valid}, 32'd1);
    check("t6_cnt_after",   {16'd0, sym_cnt},    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
